uart_cmd_decoder: RTL

Single-byte ASCII command decoder sitting directly downstream of the UART receiver inside `uart_top`. It consumes received bytes (`rx_data`/`rx_done`) and drives the 0–9999 counter's control lines (run, clear, mode). It also echoes each accepted byte back through the UART transmitter using the `tx_start`/`tx_busy` handshake, which closes the rx→tx loop at command level.

---
 rtl/uart_cmd_decoder_if.sv | 24 ++
 rtl/uart_cmd_decoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - RX byte, TX handshake and counter control bundle for uart_cmd_decoder
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       o_run;
  logic       o_mode;
  logic       o_clear;
  logic       o_err;
  logic       o_overrun;

  // master is the decoder; slave is the UART and counter side around it
  modport master (
    input  rx_data, rx_done, tx_busy,
    output tx_start, tx_data, o_run, o_mode, o_clear, o_err, o_overrun
  );

  modport slave (
    output rx_data, rx_done, tx_busy,
    input  tx_start, tx_data, o_run, o_mode, o_clear, o_err, o_overrun
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - ASCII command decoder driving counter control, with echo and a one-byte hold register
module uart_cmd_decoder #(
  parameter bit         ECHO_EN  = 1'b1,
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_decoder_if.master  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, WAIT_TX, SEND} state_t;

  state_t     state, state_next;
  logic       hold_full;
  logic [7:0] hold_data, work_data, echo_data;
  logic       run_q, mode_q, clear_q, err_q, overrun_q, tx_start_q;
  logic [7:0] tx_data_q;
  logic       take_hold, take_rx, store_rx, drop_rx;
  logic       is_run, is_stop, is_clear, is_mode, is_cmd;

  always_comb begin
    is_run   = (work_data == 8'h52) || (work_data == 8'h72);
    is_stop  = (work_data == 8'h53) || (work_data == 8'h73);
    is_clear = (work_data == 8'h43) || (work_data == 8'h63);
    is_mode  = (work_data == 8'h4D) || (work_data == 8'h6D);
    is_cmd   = is_run || is_stop || is_clear || is_mode;
  end

  always_comb begin
    state_next = state;
    take_hold  = 1'b0;
    take_rx    = 1'b0;
    store_rx   = 1'b0;
    drop_rx    = 1'b0;
    case (state)
      IDLE: begin
        // A held byte is older than a same-cycle arrival, which refills the slot
        if (hold_full) begin
          take_hold  = 1'b1;
          store_rx   = bus.rx_done;
          state_next = DECODE;
        end else if (bus.rx_done) begin
          take_rx    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE:  state_next = ECHO_EN ? WAIT_TX : IDLE;
      WAIT_TX: if (!bus.tx_busy) state_next = SEND;
      SEND:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && bus.rx_done) begin
      if (hold_full) drop_rx  = 1'b1;
      else           store_rx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      hold_data  <= 8'h00;
      work_data  <= 8'h00;
      echo_data  <= 8'h00;
      run_q      <= 1'b0;
      mode_q     <= 1'b0;
      clear_q    <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state      <= state_next;
      clear_q    <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= drop_rx;
      tx_start_q <= 1'b0;

      if (take_hold) work_data <= hold_data;
      if (take_rx)   work_data <= bus.rx_data;

      if (store_rx) begin
        hold_data <= bus.rx_data;
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end

      if (state == DECODE) begin
        if (is_run)  run_q  <= ~run_q;
        if (is_stop) run_q  <= 1'b0;
        if (is_mode) mode_q <= ~mode_q;
        clear_q   <= is_clear;
        err_q     <= ~is_cmd;
        echo_data <= is_cmd ? work_data : ERR_CHAR;
      end

      // Registered so the strobe coincides with the SEND cycle
      if (state_next == SEND) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= echo_data;
      end
    end
  end

  assign bus.o_run     = run_q;
  assign bus.o_mode    = mode_q;
  assign bus.o_clear   = clear_q;
  assign bus.o_err     = err_q;
  assign bus.o_overrun = overrun_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;

endmodule
